elevator_call_scheduler: RTL
============================

// Module: elevator_call_scheduler
// PURPOSE
//  Upstream stage of the elevator FSM: latches floor-call buttons, chooses the next target floor
//  (SCAN: keep direction while calls remain ahead) and drives the FSM's 2-bit rfloor input.
//  Sequences door dwell after each arrival. Consumes current_floor/up/down/stop from the elevator FSM.
// PARAMETERS
//  DWELL_CYCLES  50  door-open time in clk cycles after arrival (>=2)
//  DWELL_W       6   dwell counter width; 2**DWELL_W > DWELL_CYCLES
// PORTS
//  clk            in   1  system clock, rising edge
//  reset          in   1  asynchronous, active-high reset
//  call_req       in   4  per-floor call, bit f = floor f; level or pulse, sampled every cycle
//  current_floor  in   2  registered floor from elevator FSM
//  up / down      in   1  FSM motion flags
//  stop           in   1  FSM stopped flag
//  rfloor         out  2  requested floor to elevator FSM (registered)
//  pending        out  4  outstanding calls (registered)
//  door_open      out  1  high during dwell
//  busy           out  1  high when state != IDLE
//  emergency      in   1  only when ELEVATOR_EMERGENCY_EN is defined
// BEHAVIOUR
//  Reset (async, active-high): state=IDLE, pending=0, rfloor=0, dir=UP, door_open=0, busy=0, dwell_cnt=0.
//  pending_next = (pending | call_req) & ~clr; clr is a one-hot floor-clear, 0 by default.
//  Simultaneous set and clear for the same floor: clear wins.
//  States:
//   IDLE: pending==0 -> stay.
//    call_req/pending includes current_floor -> clr that bit; go DOOR_OPEN; rfloor=current_floor.
//    Otherwise pick the target. Search nearest pending floor ahead in dir.
//    If none is ahead, flip dir and pick nearest pending floor in the new dir.
//    Then rfloor<=target, dir<=(target>current_floor), go MOVING. Latency: call to rfloor = 2 cycles.
//   MOVING: rfloor held stable except intermediate stop.
//    Intermediate stop: cycle where current_floor changes and pending[current_floor]=1
//    -> rfloor<=current_floor. Original target stays pending.
//    New calls only set pending; they never retarget.
//    Arrival: stop=1 && current_floor==rfloor -> clr[rfloor], go DOOR_OPEN.
//   DOOR_OPEN: door_open=1, dwell_cnt counts 0..DWELL_CYCLES-1, then -> IDLE, door_open=0, dwell_cnt=0.
//    call_req for current_floor during dwell: cleared, dwell_cnt restarts at 0.
//  Outputs are registered; door_open/busy update the same edge as state.
//  Boundaries:
//   - floor 3 with dir=UP and only lower calls -> flip to DOWN.
//   - floor 0 mirrors this.
//   - all four calls at once from floor 0 -> serve 1,2,3 in order.
//   - call_req all-zero: no effect.
//   - reset mid-MOVING: rfloor=0, pending lost.
// CONFIGURATION
//  ELEVATOR_EMERGENCY_EN defined:
//   - emergency port exists.
//   - While emergency=1: pending forced 0, call_req ignored, rfloor<=0.
//   - state MOVING, or DOOR_OPEN with dwell frozen once at floor 0.
//   - On emergency falling edge -> IDLE.
//  Not defined: port absent, logic removed, behaviour as above.
// STRUCTURE
//  elevator_pkg: floor width (2), N_FLOORS=4, state encodings IDLE/MOVING/DOOR_OPEN, DIR_UP/DIR_DOWN.
//  Sub-module elevator_target_select (combinational).
//   Inputs: pending, current_floor, dir.
//   Outputs: target, new_dir, found.
// TESTING
//  1. Reset, floor 0, pulse call_req=4'b1000 -> rfloor=3 after 2 clk; FSM reaches 3; door_open for 50 clk; pending=0.
//  2. At 0, pending 3; call_req[1] set while FSM in 0->1 segment -> rfloor=1 when current_floor=1;
//     after dwell rfloor=3.
//  3. At floor 2 dir=UP, calls {0,1} only -> dir flips DOWN, rfloor=1 first, then 0.
//  4. IDLE at floor 1, call_req=4'b0010 -> door_open next cycle, no motion.
//     Repeat call at dwell cycle 40 -> dwell restarts; door_open 91 cycles total.
//  5. Reset asserted mid-move to 3 -> rfloor, pending, door_open, busy = 0 immediately (async).
//  6. (ELEVATOR_EMERGENCY_EN) pending {2,3}, emergency=1 at floor 1 -> pending=0, rfloor=0,
//     calls ignored; door_open holds at 0 until release.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator call scheduler.
//   FLOOR_W / N_FLOORS : floor index width and floor count (4 floors, 2 bits)
//   state_t            : scheduler states IDLE / MOVING / DOOR_OPEN
//   DIR_UP / DIR_DOWN  : single-bit travel direction encoding
package elevator_pkg;

    localparam int FLOOR_W  = 2;
    localparam int N_FLOORS = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVING    = 2'd1,
        DOOR_OPEN = 2'd2
    } state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/elevator_target_select.sv
// SCAN target picker (purely combinational).
// Ports:
//   pending       in  4  outstanding floor calls
//   current_floor in  2  floor the car is at
//   dir           in  1  current travel direction (DIR_UP / DIR_DOWN)
//   target        out 2  nearest pending floor ahead, or behind after a flip
//   new_dir       out 1  direction that leads to target
//   found         out 1  a pending floor other than current_floor exists
module elevator_target_select
    import elevator_pkg::*;
(
    input  logic [N_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]  current_floor,
    input  logic                dir,
    output logic [FLOOR_W-1:0]  target,
    output logic                new_dir,
    output logic                found
);

    logic [FLOOR_W-1:0] above_t;
    logic [FLOOR_W-1:0] below_t;
    logic               above_f;
    logic               below_f;

    // Lowest pending floor above and highest pending floor below the car.
    always_comb begin
        above_f = 1'b0;
        above_t = '0;
        below_f = 1'b0;
        below_t = '0;
        for (int i = N_FLOORS - 1; i >= 0; i--) begin
            if (pending[i] && (i > int'(current_floor))) begin
                above_f = 1'b1;
                above_t = FLOOR_W'(i);
            end
        end
        for (int i = 0; i < N_FLOORS; i++) begin
            if (pending[i] && (i < int'(current_floor))) begin
                below_f = 1'b1;
                below_t = FLOOR_W'(i);
            end
        end
    end

    // Keep heading while something is ahead; otherwise reverse.
    always_comb begin
        target  = current_floor;
        new_dir = dir;
        found   = 1'b0;
        if (dir == DIR_UP) begin
            if (above_f) begin
                target = above_t; new_dir = DIR_UP; found = 1'b1;
            end else if (below_f) begin
                target = below_t; new_dir = DIR_DOWN; found = 1'b1;
            end
        end else begin
            if (below_f) begin
                target = below_t; new_dir = DIR_DOWN; found = 1'b1;
            end else if (above_f) begin
                target = above_t; new_dir = DIR_UP; found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/elevator_call_scheduler.sv
// Elevator call scheduler: latches floor calls, picks the next target floor
// with SCAN ordering, drives the elevator FSM's rfloor request and sequences
// the door dwell after each arrival.
// Optional feature macro: ELEVATOR_EMERGENCY_EN (adds the emergency input;
// while it is high all calls are dropped and the car is sent to floor 0).
// Ports:
//   clk            in   1  rising-edge clock
//   reset          in   1  asynchronous active-high reset
//   call_req       in   4  per-floor call buttons, bit f = floor f
//   current_floor  in   2  floor reported by the elevator FSM
//   up / down      in   1  FSM motion flags
//   stop           in   1  FSM stopped flag
//   emergency      in   1  (ELEVATOR_EMERGENCY_EN only) emergency recall
//   rfloor         out  2  requested floor (registered)
//   pending        out  4  outstanding calls (registered)
//   door_open      out  1  high during door dwell
//   busy           out  1  high whenever state != IDLE
module elevator_call_scheduler
    import elevator_pkg::*;
#(
    parameter int DWELL_CYCLES = 50,
    parameter int DWELL_W      = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_FLOORS-1:0] call_req,
    input  logic [FLOOR_W-1:0]  current_floor,
    input  logic                up,
    input  logic                down,
    input  logic                stop,
`ifdef ELEVATOR_EMERGENCY_EN
    input  logic                emergency,
`endif
    output logic [FLOOR_W-1:0]  rfloor,
    output logic [N_FLOORS-1:0] pending,
    output logic                door_open,
    output logic                busy
);

    state_t               state;
    logic                 dir;
    logic [DWELL_W-1:0]   dwell_cnt;
    logic [FLOOR_W-1:0]   prev_floor;
    logic [N_FLOORS-1:0]  req;
    logic [N_FLOORS-1:0]  clr;
    logic [N_FLOORS-1:0]  pending_next;
    logic [FLOOR_W-1:0]   target;
    logic                 new_dir;
    logic                 found;
    logic                 arrived;
    logic                 floor_changed;
`ifdef ELEVATOR_EMERGENCY_EN
    logic                 emerg_q;
`endif

    elevator_target_select u_target_select (
        .pending       (pending),
        .current_floor (current_floor),
        .dir           (dir),
        .target        (target),
        .new_dir       (new_dir),
        .found         (found)
    );

    assign req           = pending | call_req;
    // stop is trusted only when neither motion flag is asserted.
    assign arrived       = stop && !up && !down && (current_floor == rfloor);
    assign floor_changed = (current_floor != prev_floor);

    // One-hot clear of the floor being served; clear beats a same-cycle set.
    always_comb begin
        clr = '0;
        case (state)
            IDLE:      if (req[current_floor])      clr[current_floor] = 1'b1;
            MOVING:    if (arrived)                 clr[rfloor]        = 1'b1;
            DOOR_OPEN: if (call_req[current_floor]) clr[current_floor] = 1'b1;
            default:   clr = '0;
        endcase
    end

    assign pending_next = req & ~clr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            pending    <= '0;
            rfloor     <= '0;
            dir        <= DIR_UP;
            door_open  <= 1'b0;
            busy       <= 1'b0;
            dwell_cnt  <= '0;
            prev_floor <= '0;
`ifdef ELEVATOR_EMERGENCY_EN
            emerg_q    <= 1'b0;
`endif
        end else begin
            prev_floor <= current_floor;
`ifdef ELEVATOR_EMERGENCY_EN
            emerg_q    <= emergency;
            if (emergency) begin
                // Recall to floor 0; dwell_cnt is deliberately frozen.
                pending <= '0;
                rfloor  <= '0;
                busy    <= 1'b1;
                if ((current_floor == '0) && stop) begin
                    state     <= DOOR_OPEN;
                    door_open <= 1'b1;
                end else begin
                    state     <= MOVING;
                    door_open <= 1'b0;
                end
            end else if (emerg_q) begin
                state     <= IDLE;
                door_open <= 1'b0;
                busy      <= 1'b0;
                dwell_cnt <= '0;
            end else begin
`else
            begin
`endif
                pending <= pending_next;
                case (state)
                    IDLE: begin
                        if (req[current_floor]) begin
                            state     <= DOOR_OPEN;
                            rfloor    <= current_floor;
                            door_open <= 1'b1;
                            busy      <= 1'b1;
                            dwell_cnt <= '0;
                        end else if (found) begin
                            state  <= MOVING;
                            rfloor <= target;
                            dir    <= new_dir;
                            busy   <= 1'b1;
                        end
                    end
                    MOVING: begin
                        if (arrived) begin
                            state     <= DOOR_OPEN;
                            door_open <= 1'b1;
                            dwell_cnt <= '0;
                        end else if (floor_changed && pending[current_floor]) begin
                            // Passing a called floor: stop here, the original
                            // target stays pending for later.
                            rfloor <= current_floor;
                        end
                    end
                    DOOR_OPEN: begin
                        if (call_req[current_floor]) begin
                            dwell_cnt <= '0;
                        end else if (dwell_cnt == DWELL_W'(DWELL_CYCLES - 1)) begin
                            state     <= IDLE;
                            door_open <= 1'b0;
                            busy      <= 1'b0;
                            dwell_cnt <= '0;
                        end else begin
                            dwell_cnt <= dwell_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        door_open <= 1'b0;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
